muldiv_sequencer: RTL

//  Multi-cycle sequencer for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_iter.sv | 85 ++++++++
 rtl/muldiv_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and funct3 decode helpers for the RV32M multiply/divide sequencer.
// MULDIV_FAST_MUL_EN selects a single-cycle multiplier in place of shift-add.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Datapath for the sequencer: one shift-add or restoring-divide step per step_i.
// With MULDIV_FAST_MUL_EN the product is formed in full on load for MUL ops.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0]   quot_o,
    output logic [WIDTH-1:0]   rem_o
);

    // hi: product upper half or partial remainder; lo: multiplier or quotient
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             div_q, div_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] diff;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] full;
`endif

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        div_d   = div_q;
        mul_sum = {1'b0, hi_q[WIDTH-1:0]}
                + {1'b0, (lo_q[0] ? m_q : '0)};
        diff    = {hi_q, lo_q[WIDTH-1]} - {2'b00, m_q};
`ifdef MULDIV_FAST_MUL_EN
        full    = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
`endif
        if (load_i) begin
            hi_d  = '0;
            lo_d  = a_i;
            m_d   = b_i;
            div_d = is_div_i;
`ifdef MULDIV_FAST_MUL_EN
            if (!is_div_i) begin
                hi_d = {1'b0, full[2*WIDTH-1:WIDTH]};
                lo_d = full[WIDTH-1:0];
            end
`endif
        end else if (step_i) begin
            if (!div_q) begin
                hi_d = {1'b0, mul_sum[WIDTH:1]};
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end else if (!diff[WIDTH+1]) begin
                hi_d = diff[WIDTH:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            m_q   <= m_d;
            div_q <= div_d;
        end
    end

    assign prod_o = {hi_q[WIDTH-1:0], lo_q};
    assign quot_o = lo_q;
    assign rem_o  = hi_q[WIDTH-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: FSM, sign handling and result register.
// MULDIV_FAST_MUL_EN routes MUL* ops PREP->FIX using a one-cycle product.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q;
    logic [2:0]         f3_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               negq_q, negr_q;
    logic [WIDTH-1:0]   result_q;
    logic               busy_q, done_q;

    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               div_zero, div_ovf, rem_op;
    logic [WIDTH-1:0]   short_res, fix_res;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot, rem, quot_fix, rem_fix;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (state_q == PREP),
        .step_i   (state_q == CALC),
        .is_div_i (is_div(f3_q)),
        .a_i      (mag_a),
        .b_i      (mag_b),
        .prod_o   (prod),
        .quot_o   (quot),
        .rem_o    (rem)
    );

    always_comb begin
        sa       = is_signed_a(f3_q) & a_q[WIDTH-1];
        sb       = is_signed_b(f3_q) & b_q[WIDTH-1];
        mag_a    = sa ? -a_q : a_q;
        mag_b    = sb ? -b_q : b_q;
        rem_op   = f3_q[1];
        div_zero = is_div(f3_q) && (b_q == '0);
        div_ovf  = ((f3_q == F3_DIV) || (f3_q == F3_REM))
                && (a_q == MIN_INT) && (b_q == '1);
        if (div_zero) begin
            short_res = rem_op ? a_q : '1;
        end else begin
            short_res = rem_op ? '0 : MIN_INT;
        end
        prod_fix = negq_q ? -prod : prod;
        quot_fix = negq_q ? -quot : quot;
        rem_fix  = negr_q ? -rem : rem;
        fix_res  = '0;
        unique case (1'b1)
            f3_q == F3_MUL:
                fix_res = prod_fix[WIDTH-1:0];
            !is_div(f3_q) && (f3_q != F3_MUL):
                fix_res = prod_fix[2*WIDTH-1:WIDTH];
            is_div(f3_q) && !rem_op:
                fix_res = quot_fix;
            default:
                fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        f3_q    <= funct3;
                        a_q     <= op_a;
                        b_q     <= op_b;
                        busy_q  <= 1'b1;
                        state_q <= PREP;
                    end
                end
                PREP: begin
                    // remainder sign follows the dividend only
                    negq_q <= sa ^ sb;
                    negr_q <= sa;
                    cnt_q  <= CNT_W'(WIDTH - 1);
                    if (div_zero || div_ovf) begin
                        result_q <= short_res;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div(f3_q)) begin
                        state_q <= FIX;
                    end
`endif
                    else begin
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    result_q <= fix_res;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign stall  = ((state_q == IDLE) && start)
                 || ((state_q != IDLE) && (state_q != DONE));

endmodule
